// File: rtl/dmg_reload_cnt.sv
// Reloading up-counter advanced on the falling edge of a gated tick level.
// On wrap from all-ones the counter either reloads immediately (RELOAD_DELAY=0)
// or passes through one cycle at zero in RELOAD_PENDING before reloading
// (RELOAD_DELAY=1). A load in the pending cycle cancels the reload and its ovf.
//
//   state             | meaning
//   ------------------+-----------------------------------------------------
//   ST_COUNT          | normal counting, load or inc applied to the counter
//   ST_RELOAD_PENDING | wrapped to zero last edge; reload_val lands next edge
module dmg_reload_cnt #(
    parameter int WIDTH        = 8,
    parameter int RELOAD_DELAY = 1
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             en,
    input  logic             tick_src,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] reload_val,
    output logic [WIDTH-1:0] q,
    output logic             ovf,
    output logic             pending
);

    typedef enum logic {
        ST_COUNT,
        ST_RELOAD_PENDING
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             g_dly_q;
    logic             g;
    logic             inc;

    // Gated tick and its falling edge; releasing en while tick_src is high
    // also looks like a falling edge and counts once.
    assign g   = en & tick_src;
    assign inc = g_dly_q & ~g;

    // Tick history register; clears on reset so the first edge never counts.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            g_dly_q <= 1'b0;
        end else begin
            g_dly_q <= g;
        end
    end

    // Counter, state and overflow registers.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= ST_COUNT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: load beats inc, wrap either reloads now or defers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        unique case (state_q)
            ST_COUNT: begin
                if (load) begin
                    cnt_d = d;
                end else if (inc) begin
                    if (cnt_q != CNT_ONES) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (RELOAD_DELAY == 1) begin
                        cnt_d   = '0;
                        state_d = ST_RELOAD_PENDING;
                    end else begin
                        cnt_d = reload_val;
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_RELOAD_PENDING: begin
                // Any inc arriving this cycle is intentionally dropped.
                state_d = ST_COUNT;
                if (load) begin
                    cnt_d = d;
                end else begin
                    cnt_d = reload_val;
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    assign q       = cnt_q;
    assign ovf     = ovf_q;
    assign pending = (RELOAD_DELAY == 1) && (state_q == ST_RELOAD_PENDING);

endmodule

// File: doc/dmg_reload_cnt.md
DMG_RELOAD_CNT -- requirements
Module: dmg_reload_cnt

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..16).
REQ-002 SHALL have parameter RELOAD_DELAY, default 1, cycles between wrap and reload/ovf (legal 0 or 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port nres  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable, gated with tick_src.
REQ-006 SHALL have port tick_src  input  1  tick source level (e.g. selected divider bit).
REQ-007 SHALL have port load  input  1  synchronous write strobe for counter.
REQ-008 SHALL have port d  input  WIDTH  value written on load.
REQ-009 SHALL have port reload_val  input  WIDTH  value loaded after wrap.
REQ-010 SHALL have port q  output  WIDTH  current counter value.
REQ-011 SHALL have port ovf  output  1  overflow pulse, one clk wide.
REQ-012 SHALL have port pending  output  1  high while in RELOAD_PENDING.

Function
REQ-013 SHALL form gated tick g = en AND tick_src, register it each clk as g_d.
REQ-014 SHALL generate inc = g_d AND NOT g (falling edge of gated tick); dropping en while tick_src=1 SHALL therefore count once.
REQ-015 SHALL have states COUNT and RELOAD_PENDING; RELOAD_PENDING exists only when RELOAD_DELAY=1.
REQ-016 In COUNT, load=1 SHALL set q<=d, ignore inc that cycle, no ovf.
REQ-017 In COUNT, inc=1 and q != all-ones SHALL set q<=q+1.
REQ-018 In COUNT, inc=1 and q = all-ones with RELOAD_DELAY=1 SHALL set q<=0, enter RELOAD_PENDING.
REQ-019 In COUNT, inc=1 and q = all-ones with RELOAD_DELAY=0 SHALL set q<=reload_val and ovf<=1 the same edge.
REQ-020 In RELOAD_PENDING without load SHALL set q<=reload_val (value sampled that cycle), ovf<=1, return to COUNT; inc that cycle SHALL be dropped.
REQ-021 In RELOAD_PENDING with load=1 SHALL set q<=d, suppress ovf and reload, return to COUNT.
REQ-022 ovf SHALL be registered, high exactly one cycle per reload, low otherwise.
REQ-023 pending SHALL equal (state == RELOAD_PENDING); constant 0 when RELOAD_DELAY=0.
REQ-024 Addition SHALL be modulo 2^WIDTH; no other outputs wrap.
REQ-025 Load on the cycle after a reload (ovf high) SHALL take effect normally (q<=d).

Reset
REQ-026 nres=0 SHALL immediately force q=0, ovf=0, g_d=0, state=COUNT, pending=0, independent of clk.
REQ-027 Reset asserted in RELOAD_PENDING SHALL discard the pending reload; no ovf after release.
REQ-028 First clk edge after nres rises SHALL NOT produce inc even if g=1 (g_d starts 0).

Verification (WIDTH=8, RELOAD_DELAY=1 unless noted)
REQ-029 SHALL cover: en=1, 4 falling edges of tick_src from q=0x10 -> q=0x14, ovf never high.
REQ-030 SHALL cover: q=0xFF, reload_val=0x80, one falling edge -> next cycle q=0x00 pending=1, following cycle q=0x80 ovf=1, then ovf=0.
REQ-031 SHALL cover: q=0xFF wraps, load=1 d=0x33 in pending cycle -> q=0x33, ovf stays 0, pending=0.
REQ-032 SHALL cover: tick_src=1, en falls 1->0 at q=0x05 -> q=0x06; tick_src falling with en=0 -> no change.
REQ-033 SHALL cover: RELOAD_DELAY=0, q=0xFF, reload_val=0xF0, one inc -> same edge q=0xF0 ovf=1, pending always 0.
REQ-034 SHALL cover: nres pulsed low during pending with q=0x00 -> q=0x00 ovf=0 immediately and for all cycles until next wrap.
